// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Four word registers in a 16-byte window; select and read_data are combinational.
module mmio_uart_tx #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] BASE_ADDR    = 32'h1000_0000,
   parameter int              CLKS_PER_BIT = 16,
   parameter int              FIFO_DEPTH   = 4
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [XLEN-1:0] address,
   input  logic [XLEN-1:0] write_data,
   input  logic            write_enable,
   output logic            select,
   output logic [XLEN-1:0] read_data,
   output logic            tx
);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FIFO_DEPTH);
   localparam logic [1:0]        REG_TXDATA = 2'd0;
   localparam logic [1:0]        REG_STATUS = 2'd1;
   localparam logic [1:0]        REG_CTRL   = 2'd2;

   typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

   state_t            state_r;
   logic [7:0]        fifo_r [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [CNT_W-1:0]  count_r;
   logic              overflow_r;
   logic              enable_r;
   logic [7:0]        shift_r;
   logic [BAUD_W-1:0] baud_r;
   logic [2:0]        bit_r;
   logic              tx_r;

   logic              wr_s;
   logic              push_s;
   logic              push_ok_s;
   logic              pop_s;
   logic              flush_s;
   logic              clr_ovf_s;
   logic              ctrl_wr_s;
   logic              full_s;
   logic              empty_s;
   logic              bit_end_s;
   logic [1:0]        reg_s;
   logic [XLEN-1:0]   status_s;
   logic [XLEN-1:0]   rdata_s;
   logic              unused_s;

   assign select    = (address[XLEN-1:4] == BASE_ADDR[XLEN-1:4]);
   assign reg_s     = address[3:2];
   assign wr_s      = write_enable && select;
   assign push_s    = wr_s && (reg_s == REG_TXDATA);
   assign flush_s   = wr_s && (reg_s == REG_CTRL) && write_data[1];
   assign clr_ovf_s = wr_s && (reg_s == REG_STATUS) && write_data[3];
   assign ctrl_wr_s = wr_s && (reg_s == REG_CTRL);
   assign full_s    = (count_r == CNT_FULL);
   assign empty_s   = (count_r == {CNT_W{1'b0}});
   assign bit_end_s = (baud_r == BAUD_LAST);
   // A new frame may start from IDLE or straight out of the last STOP cycle.
   assign pop_s     = enable_r && !empty_s &&
                      ((state_r == IDLE) || ((state_r == STOP) && bit_end_s));
   assign push_ok_s = push_s && (!full_s || pop_s);
   assign unused_s  = ^{address[1:0], write_data[XLEN-1:8]};

   always_comb begin
      status_s              = {XLEN{1'b0}};
      status_s[0]           = (state_r != IDLE);
      status_s[1]           = full_s;
      status_s[2]           = empty_s;
      status_s[3]           = overflow_r;
      status_s[8 +: CNT_W]  = count_r;
      rdata_s               = {XLEN{1'b0}};
      if (select) begin
         case (reg_s)
            REG_STATUS: rdata_s = status_s;
            REG_CTRL:   rdata_s[0] = enable_r;
            default:    rdata_s = {XLEN{1'b0}};
         endcase
      end else begin
         rdata_s = {XLEN{1'b0}};
      end
   end

   assign read_data = rdata_s;
   assign tx        = tx_r;

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_r   <= {PTR_W{1'b0}};
         rd_ptr_r   <= {PTR_W{1'b0}};
         count_r    <= {CNT_W{1'b0}};
         overflow_r <= 1'b0;
         enable_r   <= 1'b1;
      end else begin
         if (ctrl_wr_s) begin
            enable_r <= write_data[0];
         end
         if (flush_s) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
         end else begin
            if (push_ok_s) begin
               fifo_r[wr_ptr_r] <= write_data[7:0];
               wr_ptr_r         <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
               rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_s})
               2'b10:   count_r <= count_r + CNT_W'(1);
               2'b01:   count_r <= count_r - CNT_W'(1);
               default: count_r <= count_r;
            endcase
         end
         if (push_s && full_s && !pop_s) begin
            overflow_r <= 1'b1;
         end else if (clr_ovf_s) begin
            overflow_r <= 1'b0;
         end
      end
   end

   // Serialiser: shift register drains LSB-first; tx is updated on the same edge as the state.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= IDLE;
         tx_r    <= 1'b1;
         shift_r <= 8'h00;
         baud_r  <= {BAUD_W{1'b0}};
         bit_r   <= 3'd0;
      end else begin
         case (state_r)
            IDLE: begin
               baud_r <= {BAUD_W{1'b0}};
               bit_r  <= 3'd0;
               if (pop_s) begin
                  shift_r <= fifo_r[rd_ptr_r];
                  state_r <= START;
                  tx_r    <= 1'b0;
               end else begin
                  tx_r <= 1'b1;
               end
            end
            START: begin
               if (bit_end_s) begin
                  baud_r  <= {BAUD_W{1'b0}};
                  bit_r   <= 3'd0;
                  tx_r    <= shift_r[0];
                  shift_r <= {1'b0, shift_r[7:1]};
                  state_r <= DATA;
               end else begin
                  baud_r <= baud_r + BAUD_W'(1);
               end
            end
            DATA: begin
               if (bit_end_s) begin
                  baud_r <= {BAUD_W{1'b0}};
                  if (bit_r == 3'd7) begin
                     tx_r    <= 1'b1;
                     state_r <= STOP;
                  end else begin
                     tx_r    <= shift_r[0];
                     shift_r <= {1'b0, shift_r[7:1]};
                     bit_r   <= bit_r + 3'd1;
                  end
               end else begin
                  baud_r <= baud_r + BAUD_W'(1);
               end
            end
            STOP: begin
               if (bit_end_s) begin
                  baud_r <= {BAUD_W{1'b0}};
                  if (pop_s) begin
                     shift_r <= fifo_r[rd_ptr_r];
                     state_r <= START;
                     tx_r    <= 1'b0;
                  end else begin
                     state_r <= IDLE;
                     tx_r    <= 1'b1;
                  end
               end else begin
                  baud_r <= baud_r + BAUD_W'(1);
               end
            end
            default: begin
               state_r <= IDLE;
               tx_r    <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: register vector table, directed frame sequences and random traffic
// checked cycle by cycle against a frame-arithmetic reference model.
module tb_mmio_uart_tx;
   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CPB;
   localparam logic [31:0] TXDATA_A = 32'h1000_0000;
   localparam logic [31:0] STATUS_A = 32'h1000_0004;
   localparam logic [31:0] CTRL_A   = 32'h1000_0008;

   typedef struct {
      logic        we;
      logic [31:0] waddr;
      logic [31:0] wdata;
      logic [31:0] raddr;
      logic [31:0] exp_rd;
      logic        exp_sel;
   } vec_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        write_enable;
   logic        select;
   logic        tx;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference model: pending bytes, sticky overflow, enable, and the frame currently on the line.
   logic [7:0] mq[$];
   logic       m_ovf;
   logic       m_en;
   int         m_free;
   int         cur_start;
   logic [7:0] cur_byte;

   vec_t vecs[18];

   mmio_uart_tx #(
      .XLEN(32), .BASE_ADDR(32'h1000_0000), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clock(clock), .reset(reset), .address(address), .write_data(write_data),
      .write_enable(write_enable), .select(select), .read_data(read_data), .tx(tx)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_edge(input logic rst, input logic we, input logic [31:0] a,
                             input logic [31:0] d);
      logic       w;
      logic [1:0] r;
      logic       pop;
      if (rst) begin
         mq.delete();
         m_ovf     = 1'b0;
         m_en      = 1'b1;
         m_free    = 0;
         cur_start = -1;
      end else begin
         w   = we && (a[31:4] == 28'h100_0000);
         r   = a[3:2];
         pop = m_en && (mq.size() > 0) && (cyc >= m_free);
         if (pop) begin
            cur_byte  = mq.pop_front();
            cur_start = cyc;
            m_free    = cyc + FRAME;
         end
         if (w && r == 2'd2 && d[1]) begin
            mq.delete();
         end else if (w && r == 2'd0) begin
            if (mq.size() < DEPTH) mq.push_back(d[7:0]);
            else m_ovf = 1'b1;
         end
         if (w && r == 2'd1 && d[3]) m_ovf = 1'b0;
         if (w && r == 2'd2) m_en = d[0];
      end
   endtask

   function automatic logic exp_tx();
      int k;
      if (cur_start < 0 || cyc >= cur_start + FRAME) return 1'b1;
      k = (cyc - cur_start) / CPB;
      if (k == 0) return 1'b0;
      if (k <= 8) return cur_byte[k-1];
      return 1'b1;
   endfunction

   function automatic logic [31:0] model_rd(input logic [31:0] a);
      logic [31:0] v;
      v = 32'h0;
      if (a[31:4] == 28'h100_0000) begin
         if (a[3:2] == 2'd1) begin
            v[0]    = (cur_start >= 0) && (cyc < m_free);
            v[1]    = (mq.size() == DEPTH);
            v[2]    = (mq.size() == 0);
            v[3]    = m_ovf;
            v[15:8] = 8'(mq.size());
         end else if (a[3:2] == 2'd2) begin
            v[0] = m_en;
         end
      end
      return v;
   endfunction

   task automatic cycle(input logic rst, input logic we, input logic [31:0] a,
                        input logic [31:0] d);
      reset = rst; write_enable = we; address = a; write_data = d;
      @(posedge clock);
      #1;
      model_edge(rst, we, a, d);
      check("tx", {31'h0, tx}, {31'h0, exp_tx()});
      reset = 1'b0;
      write_enable = 1'b0;
   endtask

   task automatic rd_const(input logic [31:0] a, input logic [31:0] exp, input string name);
      address = a;
      #1;
      check(name, read_data, exp);
   endtask

   task automatic rd_model(input logic [31:0] a, input string name);
      address = a;
      #1;
      check(name, read_data, model_rd(a));
   endtask

   initial begin
      logic [7:0] pat;
      logic [7:0] last_dat;
      int         guard;
      reset = 1'b1; write_enable = 1'b0; address = 32'h0; write_data = 32'h0;

      vecs[0]  = '{1'b0, 32'h0,         32'h0,         STATUS_A,      32'h4,   1'b1};
      vecs[1]  = '{1'b0, 32'h0,         32'h0,         CTRL_A,        32'h1,   1'b1};
      vecs[2]  = '{1'b0, 32'h0,         32'h0,         32'h0000_0100, 32'h0,   1'b0};
      vecs[3]  = '{1'b0, 32'h0,         32'h0,         TXDATA_A,      32'h0,   1'b1};
      vecs[4]  = '{1'b0, 32'h0,         32'h0,         32'h1000_000C, 32'h0,   1'b1};
      vecs[5]  = '{1'b1, CTRL_A,        32'h0,         CTRL_A,        32'h0,   1'b1};
      vecs[6]  = '{1'b1, TXDATA_A,      32'hA5,        STATUS_A,      32'h100, 1'b1};
      vecs[7]  = '{1'b1, TXDATA_A,      32'h11,        STATUS_A,      32'h200, 1'b1};
      vecs[8]  = '{1'b1, 32'h1000_000C, 32'hFFFF_FFFF, STATUS_A,      32'h200, 1'b1};
      vecs[9]  = '{1'b1, TXDATA_A,      32'h22,        STATUS_A,      32'h300, 1'b1};
      vecs[10] = '{1'b1, TXDATA_A,      32'h33,        STATUS_A,      32'h402, 1'b1};
      vecs[11] = '{1'b1, TXDATA_A,      32'h44,        STATUS_A,      32'h40A, 1'b1};
      vecs[12] = '{1'b1, STATUS_A,      32'h8,         STATUS_A,      32'h402, 1'b1};
      vecs[13] = '{1'b1, CTRL_A,        32'h2,         STATUS_A,      32'h4,   1'b1};
      vecs[14] = '{1'b1, 32'h2000_0000, 32'h77,        STATUS_A,      32'h4,   1'b1};
      vecs[15] = '{1'b1, 32'h2000_0008, 32'h1,         CTRL_A,        32'h0,   1'b1};
      vecs[16] = '{1'b1, CTRL_A,        32'h3,         CTRL_A,        32'h1,   1'b1};
      vecs[17] = '{1'b0, 32'h0,         32'h0,         STATUS_A,      32'h4,   1'b1};

      // Reset and register map
      cycle(1'b1, 1'b0, 32'h0, 32'h0);
      cycle(1'b1, 1'b0, 32'h0, 32'h0);
      check("rst_tx", {31'h0, tx}, 32'h1);
      for (int i = 0; i < 18; i++) begin
         cycle(1'b0, vecs[i].we, vecs[i].waddr, vecs[i].wdata);
         address = vecs[i].raddr;
         #1;
         check($sformatf("vec%0d_rd", i), read_data, vecs[i].exp_rd);
         check($sformatf("vec%0d_sel", i), {31'h0, select}, {31'h0, vecs[i].exp_sel});
      end

      // Single frame 0x55: latency, bit order, busy window
      pat = 8'h55;
      cycle(1'b0, 1'b1, TXDATA_A, 32'h55);
      check("t2_tx_pre", {31'h0, tx}, 32'h1);
      rd_const(STATUS_A, 32'h100, "t2_queued");
      for (int i = 1; i <= 41; i++) begin
         cycle(1'b0, 1'b0, STATUS_A, 32'h0);
         if (i == 1) begin
            check("t2_latency", {31'h0, tx}, 32'h0);
            rd_const(STATUS_A, 32'h5, "t2_busy_first");
         end
         if (i >= 5 && i <= 36 && ((i - 5) % CPB) == 0)
            check($sformatf("t2_bit%0d", (i - 5) / CPB), {31'h0, tx},
                  {31'h0, pat[(i - 5) / CPB]});
         if (i == 40) begin
            check("t2_stop", {31'h0, tx}, 32'h1);
            rd_const(STATUS_A, 32'h5, "t2_busy_last");
         end
         if (i == 41) rd_const(STATUS_A, 32'h4, "t2_done");
      end

      // Six stores into a 4-deep FIFO with one frame in flight: sixth byte dropped
      for (int b = 1; b <= 6; b++) cycle(1'b0, 1'b1, TXDATA_A, 32'(b));
      rd_const(STATUS_A, 32'h40B, "t3_ovf");
      cycle(1'b0, 1'b1, STATUS_A, 32'h8);
      rd_const(STATUS_A, 32'h403, "t3_clear");
      for (int i = 0; i < 5 * FRAME; i++) cycle(1'b0, 1'b0, STATUS_A, 32'h0);
      rd_const(STATUS_A, 32'h4, "t3_drained");

      // Back-to-back frames: stop bit directly followed by next start bit
      cycle(1'b0, 1'b1, TXDATA_A, 32'h00);
      cycle(1'b0, 1'b1, TXDATA_A, 32'hFF);
      for (int i = 2; i <= 81; i++) begin
         cycle(1'b0, 1'b0, STATUS_A, 32'h0);
         if (i == 40) check("t4_stop1", {31'h0, tx}, 32'h1);
         if (i == 41) check("t4_start2", {31'h0, tx}, 32'h0);
         if (i == 80) rd_const(STATUS_A, 32'h5, "t4_busy_end");
         if (i == 81) rd_const(STATUS_A, 32'h4, "t4_done");
      end

      // Disabled transmitter holds the line; re-enable starts one clock later
      cycle(1'b0, 1'b1, CTRL_A, 32'h0);
      cycle(1'b0, 1'b1, TXDATA_A, 32'hA5);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 1'b0, STATUS_A, 32'h0);
         check("t5_held", {31'h0, tx}, 32'h1);
      end
      rd_const(STATUS_A, 32'h100, "t5_status");
      cycle(1'b0, 1'b1, CTRL_A, 32'h1);
      check("t5_pre", {31'h0, tx}, 32'h1);
      cycle(1'b0, 1'b0, STATUS_A, 32'h0);
      check("t5_resume", {31'h0, tx}, 32'h0);
      for (int i = 0; i < FRAME; i++) cycle(1'b0, 1'b0, STATUS_A, 32'h0);
      rd_const(STATUS_A, 32'h4, "t5_done");

      // Reset during data bit 3 with two bytes still queued
      cycle(1'b0, 1'b1, TXDATA_A, 32'h3C);
      cycle(1'b0, 1'b1, TXDATA_A, 32'hC3);
      cycle(1'b0, 1'b1, TXDATA_A, 32'h5A);
      for (int i = 3; i <= 17; i++) cycle(1'b0, 1'b0, STATUS_A, 32'h0);
      rd_const(STATUS_A, 32'h201, "t6_mid");
      cycle(1'b1, 1'b0, STATUS_A, 32'h0);
      check("t6_tx", {31'h0, tx}, 32'h1);
      rd_const(STATUS_A, 32'h4, "t6_status");
      rd_const(CTRL_A, 32'h1, "t6_ctrl");
      for (int i = 0; i < 60; i++) begin
         cycle(1'b0, 1'b0, STATUS_A, 32'h0);
         check("t6_quiet", {31'h0, tx}, 32'h1);
      end

      // Random traffic against the reference model
      for (int it = 0; it < 2500; it++) begin
         int op;
         op = $urandom_range(0, 199);
         if (op < 24)
            cycle(1'b0, 1'b1, TXDATA_A | 32'($urandom_range(0, 3)), $urandom());
         else if (op < 28)
            cycle(1'b0, 1'b1, CTRL_A,
                  {30'h0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0)});
         else if (op < 32)
            cycle(1'b0, 1'b1, STATUS_A, $urandom());
         else if (op < 36)
            cycle(1'b0, 1'b1, 32'h2000_0000 | 32'($urandom_range(0, 15)), $urandom());
         else if (op < 37)
            cycle(1'b1, 1'b0, STATUS_A, 32'h0);
         else
            cycle(1'b0, 1'b0, STATUS_A, 32'h0);
         if (it % 7 == 0) rd_model(STATUS_A, "rnd_status");
         if (it % 11 == 0) rd_model(CTRL_A, "rnd_ctrl");
      end

      // Drain with the transmitter enabled
      cycle(1'b0, 1'b1, CTRL_A, 32'h1);
      guard = 0;
      while ((mq.size() > 0 || cyc < m_free) && guard < 400) begin
         cycle(1'b0, 1'b0, STATUS_A, 32'h0);
         guard++;
      end
      if (guard >= 400) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout: queue %0d entries after %0d cycles, required 0", mq.size(), guard);
      end
      cycle(1'b0, 1'b0, STATUS_A, 32'h0);
      rd_const(STATUS_A, 32'h4, "rnd_drained");
      last_dat = 8'h00;
      check("rnd_tx_idle", {31'h0, tx}, {31'h0, ~last_dat[0]});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
